// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a show-ahead-off scfifo into a
// valid/ready stream through a two-entry skid buffer.
module fifo_stream_reader #(
  parameter int WIDTH      = 64,
  parameter int COUNT_BITS = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [WIDTH-1:0]      fifo_q,
  output logic                  fifo_rdreq,
  output logic                  fifo_sclr,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic [COUNT_BITS-1:0] word_count,
  output logic                  underflow
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]       held;
  logic             pending;
  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic             take;
  logic [2:0]       occ;
  logic [1:0]       tail;

  assign out_valid = (held != EMPTY);
  assign out_data  = slot0;
  assign fifo_sclr = reset | flush;

  // read request: room left after this cycle's take and in-flight word
  always_comb begin
    take = out_valid & out_ready;
    occ  = {1'b0, held} + {2'b0, pending} - {2'b0, take};
    tail = held - {1'b0, take};
    fifo_rdreq = !fifo_empty && !flush && !reset && (occ < 3'd2);
  end

  // occupancy state and in-flight read tracking
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      held    <= EMPTY;
      pending <= 1'b0;
    end else begin
      pending <= fifo_rdreq;
      unique case (held)
        EMPTY: if (pending) held <= ONE;
        ONE: begin
          if (pending && !take)      held <= TWO;
          else if (!pending && take) held <= EMPTY;
        end
        TWO: if (take && !pending) held <= ONE;
        default: held <= EMPTY;
      endcase
    end
  end

  // buffer slots: shift on take, capture into the post-take tail
  always_ff @(posedge clock) begin
    if (reset) begin
      slot0 <= '0;
      slot1 <= '0;
    end else if (!flush) begin
      if (take) slot0 <= slot1;
      if (pending) begin
        if (tail == 2'd0) slot0 <= fifo_q;
        else              slot1 <= fifo_q;
      end
    end
  end

  // delivered-word counter, survives flush
  always_ff @(posedge clock) begin
    if (reset)     word_count <= '0;
    else if (take) word_count <= word_count + 1'b1;
  end

  // sticky read-while-empty flag
  always_ff @(posedge clock) begin
    if (reset)                        underflow <= 1'b0;
    else if (fifo_rdreq && fifo_empty) underflow <= 1'b1;
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: fifo model plus word-order
// scoreboard, directed scenarios and random traffic.
module tb_fifo_stream_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [63:0] fifo_q = '0;
  logic        fifo_rdreq;
  logic        fifo_sclr;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready = 1'b0;
  logic [15:0] word_count;
  logic        underflow;

  logic        wr_en = 1'b0;
  logic [63:0] wr_data = '0;

  logic        w_rst = 1'b1;
  logic        w_flush = 1'b0;
  logic        w_empty;
  logic [63:0] w_q = '0;
  logic        w_rdreq;
  logic        w_sclr;
  logic        w_valid;
  logic [63:0] w_data;
  logic        w_ready = 1'b1;
  logic [3:0]  w_count;
  logic        w_under;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  fifo_stream_reader #(.WIDTH(64), .COUNT_BITS(16)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_q(fifo_q),
    .fifo_rdreq(fifo_rdreq), .fifo_sclr(fifo_sclr),
    .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .word_count(word_count),
    .underflow(underflow)
  );

  fifo_stream_reader #(.WIDTH(64), .COUNT_BITS(4)) dut_w (
    .clock(clock), .reset(w_rst), .flush(w_flush),
    .fifo_empty(w_empty), .fifo_q(w_q),
    .fifo_rdreq(w_rdreq), .fifo_sclr(w_sclr),
    .out_valid(w_valid), .out_data(w_data),
    .out_ready(w_ready), .word_count(w_count),
    .underflow(w_under)
  );

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scfifo model, show-ahead off
  logic [63:0] fq[$];
  always @(posedge clock) begin
    if (fifo_sclr) fq.delete();
    else begin
      if (fifo_rdreq && fq.size() > 0) fifo_q <= fq.pop_front();
      if (wr_en) fq.push_back(wr_data);
    end
    fifo_empty <= (fq.size() == 0);
  end

  int cyc = 0;
  always @(posedge clock) cyc++;

  // scoreboard: every accepted write must come out once, in order
  logic [63:0] exp_q[$];
  int          exp_cnt = 0;
  bit          prev_clr = 1'b1;
  int          rd_cnt = 0, valid_cnt = 0, take_cnt = 0;
  int          first_rd = -1, first_val = -1;
  int          first_take = -1, last_take = -1;
  logic [63:0] last_word = '0;

  always @(negedge clock) begin
    check("count", word_count, 64'(exp_cnt % 65536));
    if (prev_clr) check("clr_valid", out_valid, 0);
    if (fifo_rdreq) begin
      check("rd_empty", fifo_empty, 0);
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (out_valid) begin
      valid_cnt++;
      if (first_val < 0) first_val = cyc;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("extra_word", 1, 0);
      else check("order", out_data, exp_q.pop_front());
      last_word = out_data;
      if (first_take < 0) first_take = cyc;
      last_take = cyc;
      take_cnt++;
      exp_cnt++;
    end
    if (reset) exp_cnt = 0;
    if (reset || flush) exp_q.delete();
    if (wr_en && !reset && !flush) exp_q.push_back(wr_data);
    prev_clr = reset || flush;
  end

  // narrow-counter instance: source of sequential words
  int w_total = 0;
  int seq2 = 0;
  int w_exp = 0;
  assign w_empty = (seq2 >= w_total);
  always @(posedge clock) begin
    if (w_rdreq) begin
      w_q  <= 64'(seq2);
      seq2 <= seq2 + 1;
    end
  end
  always @(negedge clock) begin
    if (w_valid) begin
      check("w_order", w_data, 64'(w_exp));
      w_exp++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic write_one(logic [63:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic clear_mon();
    rd_cnt = 0; valid_cnt = 0; take_cnt = 0;
    first_rd = -1; first_val = -1;
    first_take = -1; last_take = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    check("rst_sclr", fifo_sclr, 1);
    check("rst_rdreq", fifo_rdreq, 0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_count", word_count, 0);
    check("rst_under", underflow, 0);
    tick();
  endtask

  logic [63:0] w0;

  initial begin
    tick();
    w_rst = 1'b0;
    do_reset();

    // three words, always ready
    clear_mon();
    out_ready = 1'b1;
    write_one(64'hDEA1_BEE2);
    write_one(64'hDEA3_BEE4);
    write_one(64'hDEA5_BEE6);
    idle(8);
    check("lat", 64'(first_val - first_rd), 2);
    check("three_n", 64'(take_cnt), 3);
    check("three_b2b", 64'(last_take - first_take), 2);
    check("three_cnt", word_count, 3);

    // backpressure
    do_reset();
    clear_mon();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) write_one({$urandom, $urandom});
    idle(6);
    check("bp_rd", 64'(rd_cnt), 2);
    check("bp_usedw", 64'(fq.size()), 3);
    check("bp_valid", out_valid, 1);
    w0 = out_data;
    idle(3);
    check("bp_hold", out_data, w0);
    out_ready = 1'b1;
    idle(10);
    check("bp_n", 64'(take_cnt), 5);
    check("bp_b2b", 64'(last_take - first_take), 4);
    check("bp_w0", 64'(first_take > 0), 1);

    // single word
    do_reset();
    clear_mon();
    out_ready = 1'b1;
    write_one(64'h5157_0001);
    idle(6);
    check("one_rd", 64'(rd_cnt), 1);
    check("one_vld", 64'(valid_cnt), 1);
    check("one_idle", out_valid, 0);

    // flush mid-stream
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) write_one({$urandom, $urandom});
    idle(5);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    flush = 1'b1;
    @(negedge clock);
    check("fl_rdreq", fifo_rdreq, 0);
    tick();
    flush = 1'b0;
    @(negedge clock);
    check("fl_valid", out_valid, 0);
    check("fl_fifo", 64'(fq.size()), 0);
    check("fl_count", word_count, 1);
    tick();
    out_ready = 1'b1;
    write_one(64'h1234);
    idle(6);
    check("fl_word", last_word, 64'h1234);
    check("fl_count2", word_count, 2);

    // reset while holding two
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) write_one({$urandom, $urandom});
    idle(5);
    check("two_vld", out_valid, 1);
    do_reset();
    out_ready = 1'b1;
    write_one(64'hCAFE_F00D);
    idle(6);
    check("rt_word", last_word, 64'hCAFE_F00D);
    check("rt_count", word_count, 1);

    // random traffic with occasional flush
    do_reset();
    for (int i = 0; i < 600; i++) begin
      wr_en     = ($urandom % 3) != 0;
      wr_data   = {$urandom, $urandom};
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 60) == 0;
      tick();
    end
    wr_en = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    idle(20);
    check("drain", 64'(exp_q.size()), 0);
    check("drain_vld", out_valid, 0);

    // counter wrap on 4-bit instance
    w_total = 17;
    idle(30);
    check("wrap_n", 64'(w_exp), 17);
    check("wrap_cnt", w_count, 1);
    check("w_under", w_under, 0);
    check("under", underflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
